// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC, NOP, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  // FETCH: request outstanding at fetch_pc.
  // DROP : wrong-path request still outstanding, its data will be thrown away.
  // FULL : IF/ID and skid both occupied, no request issued.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DROP  = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_skid.sv
// One-entry {pc, instr} holding register; catches a fetched word when IF/ID is stalled.
// Latency: load visible on outputs the cycle after load_i.
// Backpressure: none; owner guarantees it never loads while occupied.
// Ports: load_i/clear_i control (load wins), pc_i/instr_i data in, pc_o/instr_o held entry.
module if_skid_reg
  import if_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
    end
    if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch.sv
// MIPS instruction fetch: owns fetch PC, req/ack to imem, valid/ready IF/ID register, redirect squash.
// Latency: ack -> valid_o next cycle; redirect -> request at target next cycle (after pending ack in DROP).
// Backpressure: IF/ID stall parks one extra word in the skid entry and drops imem_req_o until drained.
// Ports: imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i memory side; valid_o/pc_o/instr_o/id_ready_i
//        decode side; redirect_i/redirect_pc_i taken branch/jump target from ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o,
  input  logic               id_ready_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  saved_pc_q, saved_pc_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  logic               skid_load, skid_clear;
  logic [ADDR_W-1:0]  skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  logic               ifid_free;
  logic [ADDR_W-1:0]  redirect_tgt;
  logic [ADDR_W-1:0]  pc_plus4;

  assign ifid_free    = !valid_q || id_ready_i;
  assign redirect_tgt = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
  assign pc_plus4     = fetch_pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    saved_pc_d = saved_pc_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (redirect_i) begin
          // The branch in IF/ID (if transferring) is consumed; everything younger dies.
          valid_d = 1'b0;
          if (imem_ack_i) begin
            fetch_pc_d = redirect_tgt;
          end else begin
            // Address must stay put until the in-flight request completes.
            saved_pc_d = redirect_tgt;
            state_d    = ST_DROP;
          end
        end else if (imem_ack_i) begin
          fetch_pc_d = pc_plus4;
          if (ifid_free) begin
            valid_d = 1'b1;
            pc_d    = fetch_pc_q;
            instr_d = imem_rdata_i;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end
        end else if (ifid_free) begin
          valid_d = 1'b0;
        end
      end

      ST_DROP: begin
        valid_d = 1'b0;
        if (redirect_i) begin
          saved_pc_d = redirect_tgt;
        end
        if (imem_ack_i) begin
          // A redirect arriving with the ack is the youngest target.
          fetch_pc_d = redirect_i ? redirect_tgt : saved_pc_q;
          state_d    = ST_FETCH;
        end
      end

      ST_FULL: begin
        if (redirect_i) begin
          valid_d    = 1'b0;
          skid_clear = 1'b1;
          fetch_pc_d = redirect_tgt;
          state_d    = ST_FETCH;
        end else if (id_ready_i) begin
          valid_d    = 1'b1;
          pc_d       = skid_pc;
          instr_d    = skid_instr;
          skid_clear = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      saved_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      saved_pc_q <= saved_pc_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  if_skid_reg u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (fetch_pc_q),
    .instr_i (imem_rdata_i),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // Gated by rst_n so no request is visible while reset is held.
  assign imem_req_o  = rst_n && (state_q != ST_FULL);
  assign imem_addr_o = fetch_pc_q;
  assign valid_o     = valid_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        id_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;

  // Second instance with a reset PC near the top of the address space.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack = 1'b1;
  logic [31:0] w_rdata = 32'h0;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_ready = 1'b1;
  logic        w_redir = 1'b0;
  logic [31:0] w_tgt = 32'h0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .id_ready_i    (id_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (w_req),
    .imem_addr_o   (w_addr),
    .imem_ack_i    (w_ack),
    .imem_rdata_i  (w_rdata),
    .valid_o       (w_valid),
    .pc_o          (w_pc),
    .instr_o       (w_instr),
    .id_ready_i    (w_ready),
    .redirect_i    (w_redir),
    .redirect_pc_i (w_tgt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: an in-order queue of words held between imem and
  // decode (IF/ID head + at most one parked word), the next fetch address, and
  // whether the outstanding request belongs to a squashed path.
  logic [63:0] m_q[$];
  logic [31:0] m_pc    = 32'h3000;
  logic [31:0] m_saved = 32'h0;
  bit          m_drop  = 1'b0;
  int          wcnt    = 0;
  int          mem_delay = 0;

  task automatic model_reset();
    m_q.delete();
    m_pc    = 32'h3000;
    m_saved = 32'h0;
    m_drop  = 1'b0;
    wcnt    = 0;
  endtask

  task automatic model_step();
    bit          req;
    logic [31:0] t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    req = (m_q.size() < 2);
    t   = redirect_pc_i & 32'hFFFF_FFFC;
    if (req && imem_ack_i) begin
      if (m_drop || redirect_i) begin
        m_pc   = redirect_i ? t : m_saved;
        m_drop = 1'b0;
      end else begin
        if (m_q.size() > 0 && id_ready_i) void'(m_q.pop_front());
        m_q.push_back({m_pc, imem_rdata_i});
        m_pc = m_pc + 32'd4;
      end
    end else if (req) begin
      if (redirect_i) begin
        m_saved = t;
        m_drop  = 1'b1;
      end else if (m_q.size() > 0 && id_ready_i) begin
        void'(m_q.pop_front());
      end
    end else begin
      if (redirect_i) m_pc = t;
      else if (id_ready_i) void'(m_q.pop_front());
    end
    if (redirect_i) m_q.delete();
  endtask

  // Applies one cycle of stimulus; memory answers after mem_delay waiting cycles
  // with data = address ^ A5A5A5A5.
  task automatic drive(input bit rdy, input bit rd, input logic [31:0] tgt);
    bit mreq;
    mreq          = rst_n && (m_q.size() < 2);
    id_ready_i    = rdy;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    if (mreq) begin
      if (wcnt >= mem_delay) begin
        imem_ack_i = 1'b1;
        wcnt       = 0;
      end else begin
        imem_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack_i = 1'b0;
      wcnt       = 0;
    end
    imem_rdata_i = m_pc ^ 32'hA5A5_A5A5;
    model_step();
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("req", {31'b0, imem_req_o}, {31'b0, (rst_n === 1'b1) && (m_q.size() < 2)});
    if (imem_req_o) chk("addr", imem_addr_o, m_pc);
    chk("valid", {31'b0, valid_o}, {31'b0, m_q.size() > 0});
    if (valid_o && m_q.size() > 0) begin
      chk("pc", pc_o, m_q[0][63:32]);
      chk("instr", instr_o, m_q[0][31:0]);
    end
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    sync();
    sync();
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_pc", pc_o, 32'h0000_3000);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFF8);

    // Streaming, 1-cycle memory, decode always ready.
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'b0, imem_req_o}, 32'h1);
    chk("rel_addr", imem_addr_o, 32'h0000_3000);
    chk("wrap_rel_addr", w_addr, 32'hFFFF_FFF8);
    drive(1, 0, 32'h0);
    sync();
    chk("p1_valid", {31'b0, valid_o}, 32'h1);
    chk("p1_pc", pc_o, 32'h0000_3000);
    chk("p1_instr", instr_o, 32'hA5A5_95A5);
    chk("p1_addr", imem_addr_o, 32'h0000_3004);
    chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0);
    sync();
    chk("p2_pc", pc_o, 32'h0000_3004);
    chk("wrap_addr2", w_addr, 32'h0000_0000);
    chk("wrap_pc2", w_pc, 32'hFFFF_FFFC);

    // Decode stall for three cycles with 0x3004 in IF/ID.
    drive(0, 0, 32'h0);
    sync();
    chk("stall_req", {31'b0, imem_req_o}, 32'h0);
    chk("stall_pc", pc_o, 32'h0000_3004);
    drive(0, 0, 32'h0);
    sync();
    chk("stall_instr", instr_o, 32'hA5A5_95A1);
    drive(0, 0, 32'h0);
    sync();
    chk("stall_pc2", pc_o, 32'h0000_3004);
    drive(1, 0, 32'h0);
    sync();
    chk("skid_pc", pc_o, 32'h0000_3008);
    chk("skid_instr", instr_o, 32'hA5A5_95AD);
    chk("resume_addr", imem_addr_o, 32'h0000_300C);
    drive(1, 0, 32'h0);
    sync();
    chk("seq_pc", pc_o, 32'h0000_300C);
    chk("seq_addr", imem_addr_o, 32'h0000_3010);

    // Redirect while a slow request is outstanding.
    mem_delay = 4;
    drive(1, 0, 32'h0);
    sync();
    drive(1, 1, 32'h0000_3100);
    for (int i = 0; i < 8 && m_drop; i++) begin
      sync();
      chk("drop_addr", imem_addr_o, 32'h0000_3010);
      chk("drop_valid", {31'b0, valid_o}, 32'h0);
      drive(1, 0, 32'h0);
    end
    sync();
    chk("redir_addr", imem_addr_o, 32'h0000_3100);
    chk("redir_valid", {31'b0, valid_o}, 32'h0);
    mem_delay = 0;
    drive(1, 0, 32'h0);
    sync();
    chk("redir_pc", pc_o, 32'h0000_3100);
    chk("redir_vld", {31'b0, valid_o}, 32'h1);

    // Redirect with ack in the same cycle, then two redirects during DROP.
    drive(1, 1, 32'h0000_3180);
    sync();
    chk("ackred_addr", imem_addr_o, 32'h0000_3180);
    chk("ackred_valid", {31'b0, valid_o}, 32'h0);
    mem_delay = 3;
    drive(1, 1, 32'h0000_3190);
    sync();
    drive(1, 1, 32'h0000_3202);
    for (int i = 0; i < 8 && m_drop; i++) begin
      sync();
      chk("drop2_addr", imem_addr_o, 32'h0000_3180);
      chk("drop2_valid", {31'b0, valid_o}, 32'h0);
      drive(1, 0, 32'h0);
    end
    sync();
    chk("drop2_tgt", imem_addr_o, 32'h0000_3200);
    mem_delay = 0;
    drive(1, 0, 32'h0);
    sync();
    chk("tgt_pc", pc_o, 32'h0000_3200);
    chk("tgt_instr", instr_o, 32'hA5A5_97A5);

    // Redirect while FULL flushes IF/ID and skid.
    drive(0, 0, 32'h0);
    sync();
    chk("full_req", {31'b0, imem_req_o}, 32'h0);
    drive(0, 1, 32'h0000_3300);
    sync();
    chk("fr_addr", imem_addr_o, 32'h0000_3300);
    chk("fr_valid", {31'b0, valid_o}, 32'h0);
    drive(1, 0, 32'h0);
    sync();
    chk("fr_pc", pc_o, 32'h0000_3300);

    // Async reset with the skid occupied.
    drive(0, 0, 32'h0);
    sync();
    chk("full2_req", {31'b0, imem_req_o}, 32'h0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_valid", {31'b0, valid_o}, 32'h0);
    chk("ar_req", {31'b0, imem_req_o}, 32'h0);
    chk("ar_pc", pc_o, 32'h0000_3000);
    sync();
    rst_n = 1'b1;
    #1;
    chk("ar_addr", imem_addr_o, 32'h0000_3000);
    drive(1, 0, 32'h0);
    sync();
    chk("ar_first_pc", pc_o, 32'h0000_3000);
    drive(1, 0, 32'h0);
    sync();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the architectural fetch PC and issues requests to instruction memory over a req/ack handshake.
- Presents the fetched {pc, instr} to the decode stage through a valid/ready IF/ID register.
- Accepts taken-branch/jump redirects (target from the next-PC calculator in ID) and squashes wrong-path fetches. No branch delay slot.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req_o  output  1  fetch request; held until imem_ack_i.
- imem_addr_o  output  32  word-aligned fetch address; stable while imem_req_o=1 and no ack.
- imem_ack_i  input  1  request completed this cycle; imem_rdata_i valid.
- imem_rdata_i  input  32  instruction word.
- valid_o  output  1  IF/ID register holds a valid instruction.
- pc_o  output  32  PC of the instruction in IF/ID; drives the next-PC calculator's pc.
- instr_o  output  32  instruction in IF/ID.
- id_ready_i  input  1  decode accepts; a transfer occurs when valid_o & id_ready_i.
- redirect_i  input  1  one-cycle pulse; taken branch/jump resolved in ID.
- redirect_pc_i  input  32  redirect target (next_pc); bits [1:0] forced to 0.

Behaviour:
- Reset (async assert, sync release)
  - state=FETCH, fetch_pc=RESET_PC, valid_o=0, pc_o=RESET_PC, instr_o=0.
  - skid empty, drop flag 0, imem_req_o=0 while rst_n=0.
  - First request (addr RESET_PC) is issued in the first cycle after release.
  - Reset mid-transaction abandons it. imem must tolerate this.
- Internal state
  - fetch_pc, one skid entry {pc, instr}, saved target, FSM {FETCH, DROP, FULL}.
- Sequential fetch: fetch_pc increments by 4 modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- IF/ID register "free" this cycle = !valid_o | id_ready_i.
- FETCH (imem_req_o=1, addr=fetch_pc)
  - ack & redirect: discard rdata, flush IF/ID (valid_o=0 next), fetch_pc=target, stay FETCH.
  - ack & !redirect & free: IF/ID<= {fetch_pc, rdata}, valid_o=1, fetch_pc+=4, stay FETCH. This gives back-to-back throughput of 1 instr/cycle with 1-cycle memory.
  - ack & !redirect & !free: skid<= {fetch_pc, rdata}, fetch_pc+=4, go FULL.
  - !ack & redirect: flush IF/ID, save target, go DROP. Address must not change while the request is outstanding.
  - !ack & !redirect & free: IF/ID valid_o cleared if it was consumed.
- DROP (imem_req_o=1, addr unchanged)
  - Another redirect overwrites the saved target.
  - ack: discard rdata, fetch_pc=saved target, go FETCH. The new address appears the next cycle.
  - valid_o stays 0 throughout.
- FULL (imem_req_o=0)
  - id_ready_i & !redirect: IF/ID<=skid, go FETCH.
  - redirect: flush IF/ID and skid, fetch_pc=target, go FETCH.
- Redirect priority
  - Redirect beats every other event in the same cycle.
  - The IF/ID instruction transferred in the redirect cycle (the branch itself, valid_o & id_ready_i) counts as consumed. Everything younger is discarded.
- IF/ID holds pc_o/instr_o stable while valid_o & !id_ready_i.
- Latency: request to valid_o is 1 cycle after the ack edge. Redirect to first request at target is 1 cycle (FETCH/FULL), or 1 cycle after the pending ack (DROP).

Decomposition:
- Shared core package holds:
  - RESET_PC default, 32'h0000_3000.
  - Fetch FSM state encoding.
  - INSTR_W=32 and ADDR_W=32.
  - NOP encoding 32'h0000_0000 used for instr_o reset.
- One natural sub-module: if_skid_reg, a one-entry {pc, instr} holding register with load/clear. Everything else stays in if_fetch.

Test Plan:
- Reset release, imem acks every cycle with rdata=addr^32'hA5A5_A5A5, id_ready_i=1 -> addrs 0x3000, 0x3004, 0x3008...; pc_o follows 1 cycle behind ack; valid_o=1 continuous from cycle 2.
- Hold id_ready_i=0 for 3 cycles at pc_o=0x3004 -> one extra word (0x3008) lands in skid, req drops, pc_o/instr_o stable. On release, 0x3008 is presented next and requests resume at 0x300C; no duplicate or loss.
- Redirect to 0x0000_3100 while req to 0x3010 is pending with 4-cycle ack delay -> addr stays 0x3010 until ack, rdata discarded, next addr 0x3100, valid_o=0 until 0x3100 data.
- Redirect and ack in same cycle, plus second redirect (0x3200) during DROP -> only 0x3200 is fetched afterwards; no wrong-path instr reaches valid_o.
- RESET_PC overridden to 32'hFFFF_FFF8 -> fetch addresses FFF8, FFFC, 0000_0000 wraparound.
- rst_n pulsed low mid-FULL with skid occupied -> valid_o=0, req=0 immediately (async); first request is 0x3000 after release.
